// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// The state encoding, default parameters and statistics counter helpers live here.
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Default configuration
  localparam int DEF_N         = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // Width of each per-requester accepted-word counter
  localparam int STATS_W = 16;

  // Saturating increment for the statistics counters
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    logic [STATS_W-1:0] r;
    if (v == {STATS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + STATS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo16x8_wr_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request at or after 'start',
// wrapping modulo N, plus a flag saying whether any request is set.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  // Scan from farthest to nearest so the closest request to 'start' is kept last
  always_comb begin
    logic [IW-1:0] idx_s;
    winner    = '0;
    any_valid = 1'b0;
    idx_s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s     = IW'((int'(start) + k) % N);
      winner    = req[idx_s] ? idx_s : winner;
      any_valid = any_valid | req[idx_s];
    end
  end

endmodule

// File: rtl/fifo16x8_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N requesters.
// An owner is granted for a burst of up to MAX_BURST words; one IDLE cycle
// separates bursts. Writes are gated combinationally by fifo_full and reset.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester accepted-word
// counters on output accept_cnt (saturating, cleared by reset).
module fifo16x8_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      wdata,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  input  logic                 fifo_full,
  output logic                 fifo_we,
`ifdef FIFO_ARB_STATS_EN
  output logic [N*STATS_W-1:0] accept_cnt,
`endif
  output logic [DW-1:0]        fifo_wr_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);

  arb_state_e    state_r, state_n;
  logic [IW-1:0] owner_r, owner_n;
  logic [IW-1:0] ptr_r, ptr_n;
  logic [CW-1:0] beat_r, beat_n;
  logic [N-1:0]  gnt_r, gnt_n;
  logic          busy_r;

  logic [IW-1:0] win_s;
  logic          any_s;
  logic          own_req_s;
  logic [CW-1:0] beat_inc_s;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req       (req),
    .start     (ptr_r),
    .winner    (win_s),
    .any_valid (any_s)
  );

  assign own_req_s  = req[owner_r];
  assign beat_inc_s = beat_r + CW'(1);
  assign gnt        = gnt_r;
  assign busy       = busy_r;

  // Write path: only the owner may write, never into a full FIFO, never during reset
  always_comb begin
    fifo_we      = 1'b0;
    ack          = '0;
    fifo_wr_data = wdata[owner_r*DW +: DW];
    if (state_r == BURST) begin
      fifo_we      = reset & own_req_s & ~fifo_full;
      ack[owner_r] = fifo_we;
    end else begin
      fifo_we = 1'b0;
      ack     = '0;
    end
  end

  // Next-state logic: grant in IDLE, count beats and release in BURST
  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    ptr_n   = ptr_r;
    beat_n  = beat_r;
    gnt_n   = gnt_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_n        = BURST;
          owner_n        = win_s;
          gnt_n          = '0;
          gnt_n[win_s]   = 1'b1;
          beat_n         = '0;
          ptr_n          = (win_s == IW'(N - 1)) ? '0 : win_s + IW'(1);
        end else begin
          gnt_n = '0;
        end
      end
      BURST: begin
        if (!own_req_s) begin
          // Owner dropped out: nothing written this cycle
          state_n = IDLE;
          gnt_n   = '0;
        end else if (fifo_we) begin
          beat_n = beat_inc_s;
          if (beat_inc_s == BURST_LAST) begin
            state_n = IDLE;
            gnt_n   = '0;
          end else begin
            state_n = BURST;
          end
        end else begin
          // FIFO full: hold the grant, count nothing
          state_n = BURST;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      beat_r  <= '0;
      gnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      ptr_r   <= ptr_n;
      beat_r  <= beat_n;
      gnt_r   <= gnt_n;
      busy_r  <= (state_n == BURST);
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_r [N];

  // Per-requester accepted-word counters, saturating at all ones
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          cnt_r[i] <= sat_inc(cnt_r[i]);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    accept_cnt = '0;
    for (int i = 0; i < N; i++) begin
      accept_cnt[i*STATS_W +: STATS_W] = cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo16x8_wr_arbiter.sv
// Bench for fifo16x8_wr_arbiter: a cycle table of directed vectors, a hand
// sequence for continuous contention, and randomized traffic against a
// transaction-level model with a 16-deep FIFO queue.
module tb_fifo16x8_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        busy;
  logic        fifo_full;
  logic        fifo_we;
  logic [7:0]  fifo_wr_data;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] accept_cnt;
`endif

  fifo16x8_wr_arbiter #(
    .N         (N),
    .DW        (DW),
    .MAX_BURST (MB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .wdata        (wdata),
    .ack          (ack),
    .gnt          (gnt),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_we      (fifo_we),
`ifdef FIFO_ARB_STATS_EN
    .accept_cnt   (accept_cnt),
`endif
    .fifo_wr_data (fifo_wr_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic        busy;
    logic        we;
    logic [3:0]  ack;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] cap[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic full, input logic [31:0] wd,
                     input logic [3:0] g, input logic b, input logic we, input logic [3:0] a,
                     input logic [7:0] d);
    vec_t v;
    v.rst = rst; v.req = rq; v.full = full; v.wd = wd;
    v.gnt = g; v.busy = b; v.we = we; v.ack = a; v.data = d;
    tbl.push_back(v);
  endtask

  // Random-phase model state
  int         m_owner;
  int         m_left;
  int         m_prio;
  int         pend[N];
  logic [7:0] cur[N];
  logic [7:0] fifo_q[$];

  initial begin
    logic [7:0]  d;
    logic [31:0] cw;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic        e_we;
    logic [3:0]  e_ack;
    logic [7:0]  e_data;
    int          phase;
    int          own;

    cw = 32'hC3C2_C1C0;

    // ---------------- directed table ----------------
    for (int k = 0; k < 10; k++) add(1'b0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h4, 1'b0, 32'h00A0_0000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      d = 8'hA0 + 8'(k);
      add(1'b1, 4'h4, 1'b0, {8'h00, d, 16'h0000}, 4'h4, 1'b1, 1'b1, 4'h4, d);
    end
    add(1'b1, 4'h4, 1'b0, 32'h00A4_0000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h4, 1'b0, 32'h00A4_0000, 4'h4, 1'b1, 1'b1, 4'h4, 8'hA4);
    add(1'b1, 4'h4, 1'b0, 32'h00A5_0000, 4'h4, 1'b1, 1'b1, 4'h4, 8'hA5);
    add(1'b1, 4'h0, 1'b0, 32'h0,         4'h4, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    // requester 1 granted while the FIFO is full
    add(1'b1, 4'h2, 1'b1, 32'h0000_B000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h2, 1'b1, 32'h0000_B000, 4'h2, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h2, 1'b1, 32'h0000_B000, 4'h2, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h2, 1'b0, 32'h0000_B000, 4'h2, 1'b1, 1'b1, 4'h2, 8'hB0);
    add(1'b1, 4'h2, 1'b1, 32'h0000_B100, 4'h2, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h2, 1'b0, 32'h0000_B100, 4'h2, 1'b1, 1'b1, 4'h2, 8'hB1);
    // owner drops after 2 words; next owner still gets a full burst
    add(1'b1, 4'h0, 1'b0, 32'h0, 4'h2, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h4, 1'b0, cw,    4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int k = 0; k < 4; k++) add(1'b1, 4'h4, 1'b0, cw, 4'h4, 1'b1, 1'b1, 4'h4, 8'hC2);
    add(1'b1, 4'h4, 1'b0, cw, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h4, 1'b0, cw, 4'h4, 1'b1, 1'b1, 4'h4, 8'hC2);
    // reset mid-burst: word not written, grant and pointer cleared
    add(1'b0, 4'h4, 1'b0, cw, 4'h4, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h9, 1'b0, cw, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h9, 1'b0, cw, 4'h1, 1'b1, 1'b1, 4'h1, 8'hC0);
    add(1'b1, 4'h8, 1'b0, cw, 4'h1, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'h8, 1'b0, cw, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);

    reset = 1'b0; req = 4'h0; wdata = 32'h0; fifo_full = 1'b0;
    repeat (2) @(posedge clock);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clock);
      reset = tbl[r].rst; req = tbl[r].req; fifo_full = tbl[r].full; wdata = tbl[r].wd;
      #1;
      check($sformatf("tbl%0d_gnt", r),  gnt,     tbl[r].gnt);
      check($sformatf("tbl%0d_busy", r), busy,    tbl[r].busy);
      check($sformatf("tbl%0d_we", r),   fifo_we, tbl[r].we);
      check($sformatf("tbl%0d_ack", r),  ack,     tbl[r].ack);
      if (tbl[r].we) check($sformatf("tbl%0d_data", r), fifo_wr_data, tbl[r].data);
      if (fifo_we === 1'b1) cap.push_back(fifo_wr_data);
    end
    check("fifo_word_count", cap.size(), 14);
    for (int k = 0; k < 6; k++) begin
      if (k < cap.size()) check($sformatf("fifo_word%0d", k), cap[k], 8'hA0 + 8'(k));
    end

    // ---------------- all requesters continuously ----------------
    @(negedge clock);
    reset = 1'b0; req = 4'h0; fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      reset = 1'b1; req = 4'hF; wdata = cw;
      #1;
      phase = c % 5;
      own   = (c / 5) % 4;
      if (phase == 0) begin
        check("rr_idle_gnt", gnt, 32'h0);
        check("rr_idle_we", fifo_we, 32'h0);
      end else begin
        check("rr_gnt", gnt, 32'd1 << own);
        check("rr_we", fifo_we, 32'h1);
        check("rr_data", fifo_wr_data, 32'hC0 + 32'(own));
      end
    end

    // ---------------- randomized traffic vs model ----------------
    @(negedge clock);
    reset = 1'b0; req = 4'h0;
    repeat (2) @(posedge clock);
    m_owner = -1; m_left = 0; m_prio = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; cur[i] = 8'h00; end
    fifo_q.delete();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 7) == 0) begin
          pend[i] = $urandom_range(1, 6);
          cur[i]  = 8'($urandom);
        end
        req[i] = (pend[i] > 0);
        wdata[i*8 +: 8] = cur[i];
      end
      fifo_full = (fifo_q.size() == 16);
      #1;
      e_gnt = 4'h0; e_busy = 1'b0; e_we = 1'b0; e_ack = 4'h0; e_data = 8'h00;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        e_busy = 1'b1;
        e_we   = req[m_owner] && !fifo_full;
        e_ack[m_owner] = e_we;
        e_data = cur[m_owner];
      end
      check("rnd_gnt",  gnt,     e_gnt);
      check("rnd_busy", busy,    e_busy);
      check("rnd_we",   fifo_we, e_we);
      check("rnd_ack",  ack,     e_ack);
      if (e_we) check("rnd_data", fifo_wr_data, e_data);

      @(posedge clock);
      if (e_we) begin
        fifo_q.push_back(e_data);
        pend[m_owner]--;
        cur[m_owner] = 8'($urandom);
      end
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) void'(fifo_q.pop_front());
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_prio + k) % N]) begin
            m_owner = (m_prio + k) % N;
            m_left  = MB;
            m_prio  = (m_owner + 1) % N;
          end
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (e_we) begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
